mem_stage: RTL
==============

# mem_stage

Memory stage plus MEM/WB pipeline register of the 16-bit five-stage pipeline. It sits between EX/MEM and the write-back stage. It issues load and store requests to a multi-cycle data memory (stall/done handshake) and stalls the upstream pipeline until each access completes. It then registers the ALU result, load data, pc+2 and write-back control that feed write-back's result mux.

## Interface
Parameters:
- `WIDTH`, 16: data and address width.

Ports:
- `clk` in 1: clock; single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `valid_in` in 1: EX/MEM holds a live instruction.
- `alu_in` in WIDTH: ALU result; the byte address for loads and stores.
- `st_data_in` in WIDTH: store data.
- `mem_rd_in`, `mem_wr_in` in 1 each: load and store; never both set.
- `pc_plus2_in` in WIDTH.
- `wa_in` in 3.
- `wd_sel_in` in 2.
- `reg_wr_in` in 1.
- `halt_in` in 1.
- `dm_addr` out WIDTH, `dm_wdata` out WIDTH, `dm_en` out 1, `dm_wr` out 1: data-memory request.
- `dm_rdata` in WIDTH, `dm_stall` in 1, `dm_done` in 1: data-memory response.
- `stall_out` out 1: combinational; upstream holds EX/MEM while high.
- `valid_out`, `alu_out`, `mem_out`, `pc_plus2_out`, `wa_out`, `wd_sel_out`, `reg_wr_out`, `halt_out`, `err_out`: registered MEM/WB fields feeding write-back.

## Operation
- `memop = valid_in & (mem_rd_in | mem_wr_in)`.
- `misal = memop & alu_in[0]`. Word accesses only.
- FSM states: IDLE, WAIT.
- IDLE, `memop & !misal`:
  - Drive `dm_en=1`, `dm_addr=alu_in`, `dm_wr=mem_wr_in`, `dm_wdata=st_data_in`.
  - `dm_stall=1`: request not accepted. Stay in IDLE, `stall_out=1`, re-issue next cycle.
  - `dm_stall=0 & dm_done=1` (hit): complete this cycle, `stall_out=0`.
  - `dm_stall=0 & dm_done=0`: accepted. Go to WAIT, `stall_out=1`.
- WAIT:
  - `dm_en=0`, `stall_out=!dm_done`.
  - On `dm_done`: capture `dm_rdata` (loads), load MEM/WB, return to IDLE.
- IDLE, non-memory op or `misal`: no request, `stall_out=0`.
- MEM/WB update:
  - Every cycle `stall_out=0`: load all `*_in` fields. `mem_out = dm_rdata` for completing loads, else 0.
  - While `stall_out=1`: load a bubble (`valid_out=0`, `reg_wr_out=0`, `halt_out=0`, `err_out=0`). Other fields hold.
- Misaligned op:
  - Passes with `err_out=1`, `reg_wr_out=0`, `halt_out=1`.
  - No memory request is made.
- `dm_done` while IDLE with no request outstanding is ignored.
- wd_sel encoding, consumed downstream: 0 ALU, 1 MEM, 2 COND (carried on ALU), 3 PC+2.

## Timing
- Reset (`rst` high at a rising edge):
  - FSM goes to IDLE.
  - All MEM/WB outputs go to 0.
  - `dm_en=0`, `stall_out=0` while in reset.
  - Reset during WAIT abandons the access; a later stray `dm_done` is ignored.
- Latency:
  - Non-memory op: 1 cycle, EX/MEM to MEM/WB.
  - Hit: 1 cycle.
  - Miss: N+1 cycles, where N is the number of cycles until `dm_done`. `stall_out` is high for N cycles.
- `dm_en` is asserted for exactly one accepted cycle per access. It stays asserted on consecutive refused cycles.
- `stall_out` falls in the same cycle `dm_done` is seen. Upstream advances at that edge.
- Back-to-back memory ops after a completion issue immediately from IDLE, with no dead cycle.
- Stores: `mem_out=0`; `reg_wr_in` is passed through unchanged (decode keeps it 0).

## Structure
- Shared package holds:
  - wd_sel constants `WD_ALU`, `WD_MEM`, `WD_COND`, `WD_PC2`.
  - FSM state encoding `MS_IDLE`, `MS_WAIT`.
- One natural sub-module, `mem_wb_reg`: the enable/bubble pipeline register built from the codebase's `dff` cells.
- FSM and request logic live in `mem_stage`.

## Test plan
- ALU op: `alu_in=0x1234`, `wd_sel=0`, `reg_wr=1`, `wa=3` → next cycle `alu_out=0x1234`, `valid_out=1`, `stall_out` never high, `dm_en=0`.
- Load hit at `0x0040`:
  - Stimulus: `dm_done=1` in the request cycle with `dm_rdata=0xBEEF`.
  - Response: `dm_en` pulses once, `stall_out=0`, next cycle `mem_out=0xBEEF`, `wd_sel_out=1`.
- Load miss:
  - Stimulus: `dm_done` arrives 3 cycles after acceptance with `0xCAFE`.
  - Response: `stall_out` high 3 cycles; bubbles (`valid_out=0`, `reg_wr_out=0`) during the stall; then `mem_out=0xCAFE`, `valid_out=1`.
- Refused request:
  - Stimulus: store to `0x0010` with `dm_stall=1` for 2 cycles.
  - Response: `dm_en` stays high with stable address and data, `stall_out=1` throughout; accepted on the third cycle.
- Misaligned load at `0x0011` → no `dm_en`; next cycle `err_out=1`, `halt_out=1`, `reg_wr_out=0`.
- Reset in WAIT, then stray `dm_done`:
  - Response: all outputs 0, FSM in IDLE, `dm_done` ignored.
  - Next op: the following ALU op completes normally in 1 cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared constants for the memory stage: write-back mux
//                select encoding and memory-stage FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    // Write-back result select, consumed by the write-back stage
    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_MEM  = 2'd1;
    localparam logic [1:0] WD_COND = 2'd2;  // condition result rides on the ALU field
    localparam logic [1:0] WD_PC2  = 2'd3;

    // Memory-stage FSM states
    localparam logic [0:0] MS_IDLE = 1'b0;
    localparam logic [0:0] MS_WAIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_stage_mem_wb_reg.sv
`default_nettype none
// ============================================================================
//  Module      : dff / mem_wb_reg
//  Description : dff is the basic enabled register cell with synchronous
//                reset. mem_wb_reg is the MEM/WB pipeline register: data
//                fields load only when the stage advances, control fields
//                load a bubble (all zero) while the stage is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Enabled register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst)       o_q <= '0;
        else if (i_en) o_q <= i_d;
    end

endmodule

module mem_wb_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_advance,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_alu,
    input  logic [WIDTH-1:0] i_mem,
    input  logic [WIDTH-1:0] i_pc_plus2,
    input  logic [2:0]       i_wa,
    input  logic [1:0]       i_wd_sel,
    input  logic             i_reg_wr,
    input  logic             i_halt,
    input  logic             i_err,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_alu,
    output logic [WIDTH-1:0] o_mem,
    output logic [WIDTH-1:0] o_pc_plus2,
    output logic [2:0]       o_wa,
    output logic [1:0]       o_wd_sel,
    output logic             o_reg_wr,
    output logic             o_halt,
    output logic             o_err
);

    localparam int c_DATA_W = 3 * WIDTH + 3 + 2;

    logic [3:0]          w_ctrl_d;
    logic [3:0]          w_ctrl_q;
    logic [c_DATA_W-1:0] w_data_q;

    // Control bits are written every cycle so a stall inserts a bubble
    assign w_ctrl_d = i_advance ? {i_valid, i_reg_wr, i_halt, i_err} : 4'b0000;

    dff #(.WIDTH(4)) u_ctrl (
        .clk  (clk),
        .rst  (rst),
        .i_en (1'b1),
        .i_d  (w_ctrl_d),
        .o_q  (w_ctrl_q)
    );

    // Data fields simply hold while stalled
    dff #(.WIDTH(c_DATA_W)) u_data (
        .clk  (clk),
        .rst  (rst),
        .i_en (i_advance),
        .i_d  ({i_alu, i_mem, i_pc_plus2, i_wa, i_wd_sel}),
        .o_q  (w_data_q)
    );

    assign {o_valid, o_reg_wr, o_halt, o_err}           = w_ctrl_q;
    assign {o_alu, o_mem, o_pc_plus2, o_wa, o_wd_sel}   = w_data_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory stage of the 16-bit pipeline. Issues word loads and
//                stores to a multi-cycle data memory (stall/done handshake),
//                stalls upstream until the access completes, and feeds the
//                MEM/WB register. Misaligned accesses are flagged, not issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] alu_in,
    input  logic [WIDTH-1:0] st_data_in,
    input  logic             mem_rd_in,
    input  logic             mem_wr_in,
    input  logic [WIDTH-1:0] pc_plus2_in,
    input  logic [2:0]       wa_in,
    input  logic [1:0]       wd_sel_in,
    input  logic             reg_wr_in,
    input  logic             halt_in,
    output logic [WIDTH-1:0] dm_addr,
    output logic [WIDTH-1:0] dm_wdata,
    output logic             dm_en,
    output logic             dm_wr,
    input  logic [WIDTH-1:0] dm_rdata,
    input  logic             dm_stall,
    input  logic             dm_done,
    output logic             stall_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] mem_out,
    output logic [WIDTH-1:0] pc_plus2_out,
    output logic [2:0]       wa_out,
    output logic [1:0]       wd_sel_out,
    output logic             reg_wr_out,
    output logic             halt_out,
    output logic             err_out
);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_memop;
    logic             w_misal;
    logic             w_req;
    logic [WIDTH-1:0] w_mem_d;

    assign w_memop = valid_in & (mem_rd_in | mem_wr_in);
    assign w_misal = w_memop & alu_in[0];
    assign w_req   = w_memop & ~w_misal;

    // State register; reset abandons any outstanding access
    always_ff @(posedge clk) begin
        if (rst) r_state <= MS_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, request strobe and upstream stall
    always_comb begin
        w_state_nxt = r_state;
        dm_en       = 1'b0;
        stall_out   = 1'b0;
        case (r_state)
            MS_IDLE: begin
                if (w_req) begin
                    dm_en = 1'b1;
                    if (dm_stall) begin
                        stall_out = 1'b1;           // refused, re-issue next cycle
                    end else if (!dm_done) begin
                        stall_out   = 1'b1;         // accepted, data not ready
                        w_state_nxt = MS_WAIT;
                    end
                end
            end
            MS_WAIT: begin
                stall_out = ~dm_done;
                if (dm_done) w_state_nxt = MS_IDLE;
            end
            default: w_state_nxt = MS_IDLE;
        endcase
        if (rst) begin
            dm_en     = 1'b0;
            stall_out = 1'b0;
        end
    end

    assign dm_addr  = alu_in;
    assign dm_wdata = st_data_in;
    assign dm_wr    = dm_en & mem_wr_in;

    // Load data is only meaningful on the cycle a load completes
    assign w_mem_d = (mem_rd_in & w_req) ? dm_rdata : '0;

    mem_wb_reg #(.WIDTH(WIDTH)) u_mem_wb (
        .clk        (clk),
        .rst        (rst),
        .i_advance  (~stall_out),
        .i_valid    (valid_in),
        .i_alu      (alu_in),
        .i_mem      (w_mem_d),
        .i_pc_plus2 (pc_plus2_in),
        .i_wa       (wa_in),
        .i_wd_sel   (wd_sel_in),
        .i_reg_wr   (reg_wr_in & ~w_misal),
        .i_halt     (halt_in | w_misal),
        .i_err      (w_misal),
        .o_valid    (valid_out),
        .o_alu      (alu_out),
        .o_mem      (mem_out),
        .o_pc_plus2 (pc_plus2_out),
        .o_wa       (wa_out),
        .o_wd_sel   (wd_sel_out),
        .o_reg_wr   (reg_wr_out),
        .o_halt     (halt_out),
        .o_err      (err_out)
    );

endmodule
`default_nettype wire
